// File: rtl/ternary_mvm_stream.sv
// ternary_mvm_stream: streaming ternary (+1/0/-1) matrix-vector multiplier.
// An input vector arrives LANES elements per beat. It is accumulated against
// a flat ternary weight bus. At the last beat, the results are shifted,
// reduced to BIT_WIDTH and parked in a one-frame output buffer. The buffer
// then drains one word per cycle while the next vector accumulates.
module ternary_mvm_stream #(
    parameter int IN_LEN    = 16,
    parameter int OUT_LEN   = 8,
    parameter int BIT_WIDTH = 8,
    parameter int LANES     = 2,
    parameter int ACC_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*BIT_WIDTH-1:0]      in_data,
    input  logic [2*IN_LEN*OUT_LEN-1:0]     w,
    input  logic [$clog2(ACC_WIDTH)-1:0]    shift,
    input  logic                            sat_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BIT_WIDTH-1:0]            out_data,
    output logic                            out_last
);

    localparam int BEATS  = IN_LEN / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RD_W   = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int SHIFT_W = $clog2(ACC_WIDTH);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [RD_W-1:0]   LAST_RD   = RD_W'(OUT_LEN - 1);

    // Clamp limits of a signed BIT_WIDTH word, held at accumulator width
    // so they can be compared directly against the shifted sum.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (BIT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2 ** (BIT_WIDTH - 1)));

    logic [BEAT_W-1:0]           beat;
    logic signed [ACC_WIDTH-1:0] acc      [OUT_LEN];
    logic signed [ACC_WIDTH-1:0] acc_next [OUT_LEN];
    logic [BIT_WIDTH-1:0]        reduced  [OUT_LEN];
    logic [BIT_WIDTH-1:0]        out_buf  [OUT_LEN];
    logic                        buf_full;
    logic [RD_W-1:0]             rd;

    logic accept;
    logic commit;
    logic drain;

    // Contribution of one input element through one ternary weight:
    // 01 adds x, 11 subtracts x, and both zero codes (00, 10) contribute nothing.
    function automatic logic signed [ACC_WIDTH-1:0] ternary_term(
        input logic [1:0]           wt,
        input logic [BIT_WIDTH-1:0] x
    );
        logic signed [ACC_WIDTH-1:0] ext;
        ext = {{(ACC_WIDTH - BIT_WIDTH){x[BIT_WIDTH-1]}}, x};
        case (wt)
            2'b01:   return ext;
            2'b11:   return -ext;
            default: return '0;
        endcase
    endfunction

    // Arithmetic right shift followed by either a clamp or a plain wrap
    // down to the output width.
    function automatic logic [BIT_WIDTH-1:0] reduce_word(
        input logic signed [ACC_WIDTH-1:0] s,
        input logic [SHIFT_W-1:0]          sh,
        input logic                        sat
    );
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = s >>> sh;
        if (sat && (shifted > SAT_MAX)) begin
            return SAT_MAX[BIT_WIDTH-1:0];
        end else if (sat && (shifted < SAT_MIN)) begin
            return SAT_MIN[BIT_WIDTH-1:0];
        end else begin
            return shifted[BIT_WIDTH-1:0];
        end
    endfunction

    // Only the final beat can stall: it would overwrite a buffer that is
    // still draining. Earlier beats only touch the accumulators.
    assign in_ready = !((beat == LAST_BEAT) && buf_full);
    assign accept   = in_valid && in_ready;
    assign commit   = accept && !clear && (beat == LAST_BEAT);
    assign drain    = buf_full && out_ready;

    assign out_valid = buf_full;
    assign out_data  = buf_full ? out_buf[rd] : '0;
    assign out_last  = buf_full && (rd == LAST_RD);

    // Next accumulator values: beat 0 restarts from zero, so a cleared or
    // completed frame needs no explicit accumulator wipe.
    always_comb begin
        for (int j = 0; j < OUT_LEN; j++) begin
            acc_next[j] = (beat == '0) ? '0 : acc[j];
            for (int k = 0; k < LANES; k++) begin
                acc_next[j] = acc_next[j] + ternary_term(
                    w[2 * ((int'(beat) * LANES + k) * OUT_LEN + j) +: 2],
                    in_data[k * BIT_WIDTH +: BIT_WIDTH]);
            end
        end
    end

    // Post-processing of the just-completed sums, used only on a commit cycle.
    always_comb begin
        for (int j = 0; j < OUT_LEN; j++) begin
            reduced[j] = reduce_word(acc_next[j], shift, sat_en);
        end
    end

    // Beat counter and accumulators; clear wins over a simultaneous beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
            for (int j = 0; j < OUT_LEN; j++) begin
                acc[j] <= '0;
            end
        end else if (clear) begin
            beat <= '0;
        end else if (accept) begin
            for (int j = 0; j < OUT_LEN; j++) begin
                acc[j] <= acc_next[j];
            end
            beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        end
    end

    // Output buffer: a commit loads it. Accepted words advance rd, and the
    // last accepted word frees the buffer. A commit needs an empty buffer
    // and draining needs a full one, so the two never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            rd       <= '0;
            for (int j = 0; j < OUT_LEN; j++) begin
                out_buf[j] <= '0;
            end
        end else if (commit) begin
            for (int j = 0; j < OUT_LEN; j++) begin
                out_buf[j] <= reduced[j];
            end
            buf_full <= 1'b1;
            rd       <= '0;
        end else if (drain) begin
            if (rd == LAST_RD) begin
                buf_full <= 1'b0;
                rd       <= '0;
            end else begin
                rd <= rd + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_mvm_stream.sv
// Self-checking bench for ternary_mvm_stream: directed scenarios plus
// randomized streaming, checked against an integer reference model.
module tb_ternary_mvm_stream;

    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 8;
    localparam int BW      = 8;
    localparam int LANES   = 2;
    localparam int ACC     = 12;
    localparam int BEATS   = IN_LEN / LANES;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        clear = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    logic [LANES*BW-1:0]         in_data = '0;
    logic [2*IN_LEN*OUT_LEN-1:0] w = '0;
    logic [3:0]                  shift = '0;
    logic                        sat_en = 1'b0;
    logic                        out_valid;
    logic                        out_ready = 1'b0;
    logic [BW-1:0]               out_data;
    logic                        out_last;

    int vectors;
    int miscompares;

    // Current frame as seen by the model: input values and weight codes.
    int         fx [IN_LEN];
    logic [1:0] wc [IN_LEN][OUT_LEN];
    int         exp_q [$];

    ternary_mvm_stream #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .BIT_WIDTH(BW),
        .LANES(LANES), .ACC_WIDTH(ACC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w(w), .shift(shift), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap_to(input int v, input int bits);
        int m;
        m = 1 << bits;
        v = v % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        return v;
    endfunction

    // Reference result j: a plain dot product, wrapped to the accumulator
    // width, floor-divided by 2^sh, then clamped or wrapped to BW.
    function automatic int ref_word(input int j, input int sh, input bit sat);
        int s;
        s = 0;
        for (int i = 0; i < IN_LEN; i++) begin
            if (wc[i][j] == 2'b01) s += fx[i];
            else if (wc[i][j] == 2'b11) s -= fx[i];
        end
        s = wrap_to(s, ACC);
        s = s >>> sh;
        if (sat) begin
            if (s > 127) s = 127;
            else if (s < -128) s = -128;
        end else begin
            s = wrap_to(s, BW);
        end
        return s;
    endfunction

    function automatic logic [LANES*BW-1:0] beat_data(input int b);
        logic [LANES*BW-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) d[k*BW +: BW] = BW'(fx[b*LANES+k]);
        return d;
    endfunction

    task automatic pack_weights();
        for (int i = 0; i < IN_LEN; i++)
            for (int j = 0; j < OUT_LEN; j++)
                w[2*(i*OUT_LEN+j) +: 2] = wc[i][j];
    endtask

    task automatic fill_inputs(input int v);
        for (int i = 0; i < IN_LEN; i++) fx[i] = v;
    endtask

    task automatic fill_weights(input logic [1:0] code);
        for (int i = 0; i < IN_LEN; i++)
            for (int j = 0; j < OUT_LEN; j++) wc[i][j] = code;
        pack_weights();
    endtask

    task automatic randomize_frame();
        for (int i = 0; i < IN_LEN; i++) begin
            fx[i] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < OUT_LEN; j++) wc[i][j] = 2'($urandom_range(0, 3));
        end
        shift  = 4'($urandom_range(0, 9));
        sat_en = 1'($urandom_range(0, 1));
        pack_weights();
    endtask

    task automatic test_reset();
        cycle();
        cycle();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got ready=%b valid=%b data=%h last=%b, want 1 0 00 0",
                     in_ready, out_valid, out_data, out_last);
        end
        rst_n = 1'b1;
        cycle();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    // Drives one full frame with out_ready high, then checks latency, all
    // words, out_last and the return to idle.
    task automatic run_directed_frame(input string name);
        int exp [OUT_LEN];
        pack_weights();
        for (int j = 0; j < OUT_LEN; j++) exp[j] = ref_word(j, int'(shift), sat_en);
        out_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            in_valid = 1'b1;
            in_data  = beat_data(b);
            cycle();
        end
        in_valid = 1'b0;
        for (int j = 0; j < OUT_LEN; j++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== BW'(exp[j]) || out_last !== (j == OUT_LEN - 1)) begin
                miscompares++;
                $display("[TB] FAIL %s word %0d: got valid=%b data=%0d last=%b, want valid=1 data=%0d last=%b",
                         name, j, out_valid, $signed(out_data), out_last, exp[j], (j == OUT_LEN - 1));
            end
            cycle();
        end
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL %s idle: got valid=%b data=%h, want 0 00", name, out_valid, out_data);
        end
    endtask

    task automatic test_basic();
        fill_weights(2'b01);
        fill_inputs(1);
        shift  = 4'd0;
        sat_en = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_pre: got valid=%b, want 0", out_valid);
        end
        run_directed_frame("basic");
    endtask

    task automatic test_saturate_wrap();
        fill_weights(2'b01);
        fill_inputs(127);
        shift  = 4'd0;
        sat_en = 1'b1;
        run_directed_frame("saturate");
        sat_en = 1'b0;
        run_directed_frame("wrap");
    endtask

    task automatic test_mixed_shift();
        fill_inputs(5);
        for (int i = 0; i < IN_LEN; i++) begin
            for (int j = 0; j < OUT_LEN; j++) wc[i][j] = 2'b01;
            wc[i][0] = 2'b11;
            wc[i][1] = (i % 2 == 0) ? 2'b01 : 2'b11;
            wc[i][2] = 2'b10;
        end
        shift  = 4'd2;
        sat_en = 1'b0;
        run_directed_frame("mixed_shift");
    endtask

    task automatic test_backpressure();
        int e;
        fill_weights(2'b01);
        shift     = 4'd0;
        sat_en    = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        fill_inputs(1);
        for (int j = 0; j < OUT_LEN; j++) exp_q.push_back(ref_word(j, 0, 1'b0));
        for (int b = 0; b < BEATS; b++) begin
            in_valid = 1'b1;
            in_data  = beat_data(b);
            cycle();
        end
        fill_inputs(2);
        for (int j = 0; j < OUT_LEN; j++) exp_q.push_back(ref_word(j, 0, 1'b0));
        for (int b = 0; b < BEATS - 1; b++) begin
            in_data = beat_data(b);
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bp_beat%0d_ready: got %b, want 1", b, in_ready);
            end
            cycle();
        end
        in_data = beat_data(BEATS - 1);
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== BW'(exp_q[0]) || out_last !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_stall: got ready=%b valid=%b data=%0d last=%b, want 0 1 %0d 0",
                         in_ready, out_valid, $signed(out_data), out_last, exp_q[0]);
            end
            cycle();
        end
        out_ready = 1'b1;
        for (int j = 0; j < OUT_LEN; j++) begin
            e = exp_q.pop_front();
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== BW'(e) || out_last !== (j == OUT_LEN - 1)) begin
                miscompares++;
                $display("[TB] FAIL bp_first word %0d: got ready=%b valid=%b data=%0d last=%b, want 0 1 %0d %b",
                         j, in_ready, out_valid, $signed(out_data), out_last, e, (j == OUT_LEN - 1));
            end
            cycle();
        end
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_free: got ready=%b valid=%b, want 1 0", in_ready, out_valid);
        end
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < OUT_LEN; j++) begin
            e = exp_q.pop_front();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== BW'(e) || out_last !== (j == OUT_LEN - 1)) begin
                miscompares++;
                $display("[TB] FAIL bp_second word %0d: got valid=%b data=%0d last=%b, want 1 %0d %b",
                         j, out_valid, $signed(out_data), out_last, e, (j == OUT_LEN - 1));
            end
            cycle();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_idle: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_clear();
        fill_weights(2'b01);
        shift     = 4'd0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        fill_inputs(100);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = beat_data(b);
            cycle();
        end
        in_data = beat_data(3);
        clear   = 1'b1;
        cycle();
        clear    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL clear_quiet: got valid=%b ready=%b, want 0 1", out_valid, in_ready);
            end
            cycle();
        end
        fill_inputs(1);
        run_directed_frame("after_clear");
    endtask

    task automatic test_reset_mid_drain();
        int exp [OUT_LEN];
        fill_weights(2'b01);
        fill_inputs(1);
        shift     = 4'd0;
        sat_en    = 1'b0;
        out_ready = 1'b1;
        for (int j = 0; j < OUT_LEN; j++) exp[j] = ref_word(j, 0, 1'b0);
        for (int b = 0; b < BEATS; b++) begin
            in_valid = 1'b1;
            in_data  = beat_data(b);
            cycle();
        end
        in_data = {LANES{8'd50}};
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== BW'(exp[j])) begin
                miscompares++;
                $display("[TB] FAIL drain word %0d: got valid=%b data=%0d, want 1 %0d",
                         j, out_valid, $signed(out_data), exp[j]);
            end
            cycle();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got valid=%b ready=%b data=%h last=%b, want 0 1 00 0",
                     out_valid, in_ready, out_data, out_last);
        end
        cycle();
        rst_n = 1'b1;
        cycle();
        run_directed_frame("reset_fresh");
    endtask

    // Random stream against a queue-based model: the buffer is occupied
    // while undelivered words remain, and beats are counted per frame.
    task automatic test_stream(input string name, input int frames, input int valid_pct, input int ready_pct);
        int  bbeat, commits, words, wi, cyc;
        bit  regen, model_ready, fire_out;
        bbeat = 0; commits = 0; words = 0; wi = 0; cyc = 0;
        exp_q.delete();
        randomize_frame();
        while (words < frames * OUT_LEN && cyc < frames * 40 + 100) begin
            in_valid  = (commits < frames) && ($urandom_range(1, 100) <= valid_pct);
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            in_data   = beat_data(bbeat);
            model_ready = !(bbeat == BEATS - 1 && exp_q.size() > 0);
            vectors++;
            if (in_ready !== model_ready || out_valid !== (exp_q.size() > 0)) begin
                miscompares++;
                $display("[TB] FAIL %s handshake cyc %0d: got ready=%b valid=%b, want %b %b",
                         name, cyc, in_ready, out_valid, model_ready, (exp_q.size() > 0));
            end
            vectors++;
            if (exp_q.size() > 0) begin
                if (out_data !== BW'(exp_q[0]) || out_last !== (wi == OUT_LEN - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL %s word %0d cyc %0d: got data=%0d last=%b, want %0d %b",
                             name, wi, cyc, $signed(out_data), out_last, exp_q[0], (wi == OUT_LEN - 1));
                end
            end else if (out_data !== '0 || out_last !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL %s idle cyc %0d: got data=%h last=%b, want 00 0",
                         name, cyc, out_data, out_last);
            end
            fire_out = out_ready && (exp_q.size() > 0);
            if (fire_out) begin
                void'(exp_q.pop_front());
                wi = (wi + 1) % OUT_LEN;
                words++;
            end
            regen = 1'b0;
            if (in_valid && model_ready) begin
                if (bbeat == BEATS - 1) begin
                    for (int j = 0; j < OUT_LEN; j++) exp_q.push_back(ref_word(j, int'(shift), sat_en));
                    bbeat = 0;
                    commits++;
                    regen = 1'b1;
                end else begin
                    bbeat++;
                end
            end
            cycle();
            cyc++;
            if (regen) randomize_frame();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (words != frames * OUT_LEN) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: got %0d words, want %0d", name, words, frames * OUT_LEN);
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_saturate_wrap();
        test_mixed_shift();
        test_backpressure();
        test_clear();
        test_reset_mid_drain();
        test_stream("random", 25, 70, 60);
        test_stream("back_to_back", 10, 100, 100);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
